// File: rtl/gpu_pkg.sv
// Shared GPU front-end types: dispatcher FSM states and the id/counter widths
// used between the dispatcher and the cores.
package gpu_pkg;

   localparam int ID_W  = 8;   // thread-count and block-id width
   localparam int BLK_W = 9;   // block counters; one bit wider so 256 blocks fit

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_CORE_RST = 2'd1,
      S_RUN      = 2'd2,
      S_DONE     = 2'd3
   } disp_state_t;

endpackage

// File: rtl/free_core_sel.sv
// Combinational lowest-index picker: one-hot grant of the lowest eligible core.
module free_core_sel #(
   parameter int N = 2
) (
   input  logic [N-1:0] eligible,
   output logic [N-1:0] grant,
   output logic         valid
);

   // x & -x isolates the lowest set bit.
   assign grant = eligible & (~eligible + N'(1));
   assign valid = |eligible;

endmodule

// File: rtl/dispatcher.sv
// Kernel block dispatcher: splits a launch into fixed-size thread blocks and
// hands them out to idle cores, resetting each core around every block.
module dispatcher
   import gpu_pkg::*;
#(
   parameter int NUM_CORES         = 2,
   parameter int THREADS_PER_BLOCK = 4,
   localparam int TC_W             = $clog2(THREADS_PER_BLOCK) + 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [ID_W-1:0]             thread_count,
   input  logic [NUM_CORES-1:0]        core_done,
   output logic [NUM_CORES-1:0]        core_start,
   output logic [NUM_CORES-1:0]        core_reset,
   output logic [NUM_CORES*ID_W-1:0]   core_block_id,
   output logic [NUM_CORES*TC_W-1:0]   core_thread_count,
   output logic                        busy,
   output logic                        done
);

   localparam int LOG_TPB = $clog2(THREADS_PER_BLOCK);

   disp_state_t          state, state_nxt;
   logic [ID_W-1:0]      count_q;
   logic [BLK_W-1:0]     total_q, dispatched_q, completed_q, n_done;
   logic [NUM_CORES-1:0] eligible, grant, done_acc;
   logic                 grant_vld, dispatch_en, launch;
   logic [15:0]          remaining;
   logic [TC_W-1:0]      blk_tc;

   // A core still in its reset pulse is not yet ready for a new block.
   assign eligible = ~core_start & ~core_reset;

   free_core_sel #(.N(NUM_CORES)) u_sel (
      .eligible (eligible),
      .grant    (grant),
      .valid    (grant_vld)
   );

   assign dispatch_en = (state == S_RUN) && grant_vld && (dispatched_q < total_q);
   assign done_acc    = core_done & core_start;
   assign launch      = (state == S_IDLE) && (state_nxt == S_CORE_RST);

   // Threads left for the block about to go out; the last block may be short.
   assign remaining = {8'd0, count_q} - ({7'd0, dispatched_q} << LOG_TPB);
   assign blk_tc    = (remaining > 16'(THREADS_PER_BLOCK)) ? TC_W'(THREADS_PER_BLOCK)
                                                           : TC_W'(remaining);

   always_comb begin
      n_done = '0;
      for (int i = 0; i < NUM_CORES; i++)
         n_done = n_done + BLK_W'(done_acc[i]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (start) state_nxt = (thread_count == '0) ? S_DONE : S_CORE_RST;
         S_CORE_RST: state_nxt = S_RUN;
         S_RUN:      if (completed_q == total_q) state_nxt = S_DONE;
         S_DONE:     if (!start) state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q      <= '0;
         total_q      <= '0;
         dispatched_q <= '0;
         completed_q  <= '0;
         core_start   <= '0;
         core_reset   <= '0;
      end else begin
         core_reset <= launch ? '1 : ((state == S_RUN) ? done_acc : '0);
         if (state == S_IDLE && start) begin
            count_q      <= thread_count;
            total_q      <= BLK_W'((16'(thread_count) + 16'(THREADS_PER_BLOCK - 1)) >> LOG_TPB);
            dispatched_q <= '0;
            completed_q  <= '0;
         end
         if (state == S_RUN) begin
            core_start  <= (core_start & ~done_acc) | (dispatch_en ? grant : '0);
            completed_q <= completed_q + n_done;
            if (dispatch_en) dispatched_q <= dispatched_q + BLK_W'(1);
         end
      end
   end

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
      logic [ID_W-1:0] id_q;
      logic [TC_W-1:0] tc_q;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            id_q <= '0;
            tc_q <= '0;
         end else if (dispatch_en && grant[g]) begin
            id_q <= dispatched_q[ID_W-1:0];
            tc_q <= blk_tc;
         end
      end

      assign core_block_id[g*ID_W +: ID_W]     = id_q;
      assign core_thread_count[g*TC_W +: TC_W] = tc_q;
   end

   assign busy = (state == S_CORE_RST) || (state == S_RUN);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_dispatcher.sv
// Directed bench for dispatcher with 2 cores, 4 threads per block.
module tb_dispatcher;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  thread_count;
   logic [1:0]  core_done;
   logic [1:0]  core_start;
   logic [1:0]  core_reset;
   logic [15:0] core_block_id;
   logic [5:0]  core_thread_count;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   dispatcher #(.NUM_CORES(2), .THREADS_PER_BLOCK(4)) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .thread_count      (thread_count),
      .core_done         (core_done),
      .core_start        (core_start),
      .core_reset        (core_reset),
      .core_block_id     (core_block_id),
      .core_thread_count (core_thread_count),
      .busy              (busy),
      .done              (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // expected {core_start[1:0], core_reset[1:0], busy, done}
   task automatic ctl(input string tag, input logic [5:0] exp);
      chk(tag, 32'({core_start, core_reset, busy, done}), 32'(exp));
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; thread_count = 8'd0; core_done = 2'b00;
      #3;
      ctl("rst_ctl", 6'b00_00_0_0);
      chk("rst_id", 32'(core_block_id), 32'h0);
      chk("rst_tc", 32'(core_thread_count), 32'h0);
      tick();
      reset = 1'b1;
      tick();
      ctl("idle_ctl", 6'b00_00_0_0);

      // 8 threads: two full blocks; thread_count changes mid-run are ignored
      thread_count = 8'd8; start = 1'b1;
      tick(); ctl("A_corerst", 6'b00_11_1_0);
      tick(); ctl("A_run0", 6'b00_00_1_0);
      tick(); ctl("A_disp0", 6'b01_00_1_0);
      chk("A_id0", 32'(core_block_id[7:0]), 32'd0);
      chk("A_tc0", 32'(core_thread_count[2:0]), 32'd4);
      thread_count = 8'd200;
      tick(); ctl("A_disp1", 6'b11_00_1_0);
      chk("A_ids", 32'(core_block_id), 32'h0100);
      chk("A_tcs", 32'(core_thread_count), 32'h24);
      core_done = 2'b11;
      tick(); ctl("A_ack", 6'b00_11_1_0);
      core_done = 2'b00;
      tick(); ctl("A_done", 6'b00_00_0_1);
      tick(); ctl("A_hold", 6'b00_00_0_1);
      chk("A_ids_end", 32'(core_block_id), 32'h0100);
      start = 1'b0;
      tick(); ctl("A_idle", 6'b00_00_0_0);

      // 10 threads: short last block; start drop mid-run ignored
      thread_count = 8'd10; start = 1'b1;
      tick(); ctl("B_corerst", 6'b00_11_1_0);
      tick(); ctl("B_run0", 6'b00_00_1_0);
      tick(); ctl("B_disp0", 6'b01_00_1_0);
      tick(); ctl("B_disp1", 6'b11_00_1_0);
      start = 1'b0; core_done = 2'b10;
      tick(); ctl("B_ack1", 6'b01_10_1_0);
      core_done = 2'b00;
      tick(); ctl("B_wait", 6'b01_00_1_0);
      tick(); ctl("B_disp2", 6'b11_00_1_0);
      chk("B_ids", 32'(core_block_id), 32'h0200);
      chk("B_tcs", 32'(core_thread_count), 32'h14);
      core_done = 2'b11;
      tick(); ctl("B_ack", 6'b00_11_1_0);
      core_done = 2'b00;
      tick(); ctl("B_done", 6'b00_00_0_1);
      tick(); ctl("B_idle", 6'b00_00_0_0);

      // zero threads: straight to DONE with no core activity
      thread_count = 8'd0; start = 1'b1;
      tick(); ctl("C_done", 6'b00_00_0_1);
      tick(); ctl("C_hold", 6'b00_00_0_1);
      start = 1'b0;
      tick(); ctl("C_idle", 6'b00_00_0_0);

      // 9 threads: simultaneous completion, stray done on idle core ignored
      thread_count = 8'd9; start = 1'b1;
      tick(); ctl("D_corerst", 6'b00_11_1_0);
      tick(); ctl("D_run0", 6'b00_00_1_0);
      tick(); ctl("D_disp0", 6'b01_00_1_0);
      tick(); ctl("D_disp1", 6'b11_00_1_0);
      core_done = 2'b11;
      tick(); ctl("D_ack2", 6'b00_11_1_0);
      core_done = 2'b00;
      tick(); ctl("D_wait", 6'b00_00_1_0);
      tick(); ctl("D_disp2", 6'b01_00_1_0);
      chk("D_ids", 32'(core_block_id), 32'h0102);
      chk("D_tcs", 32'(core_thread_count), 32'h21);
      core_done = 2'b10;
      tick(); ctl("D_stray", 6'b01_00_1_0);
      core_done = 2'b01;
      tick(); ctl("D_ack", 6'b00_01_1_0);
      core_done = 2'b00;
      tick(); ctl("D_done", 6'b00_00_0_1);
      start = 1'b0;
      tick(); ctl("D_idle", 6'b00_00_0_0);

      // async reset mid-run, then relaunch from block 0
      thread_count = 8'd8; start = 1'b1;
      tick(); tick(); tick();
      ctl("E_disp0", 6'b01_00_1_0);
      #2 reset = 1'b0;
      #1;
      ctl("E_async", 6'b00_00_0_0);
      chk("E_id_clr", 32'(core_block_id), 32'h0);
      chk("E_tc_clr", 32'(core_thread_count), 32'h0);
      start = 1'b0;
      tick();
      reset = 1'b1;
      tick(); ctl("E_idle", 6'b00_00_0_0);
      thread_count = 8'd4; start = 1'b1;
      tick(); ctl("E_corerst", 6'b00_11_1_0);
      tick(); ctl("E_run0", 6'b00_00_1_0);
      tick(); ctl("E_disp0b", 6'b01_00_1_0);
      chk("E_ids", 32'(core_block_id), 32'h0000);
      chk("E_tcs", 32'(core_thread_count), 32'h04);
      core_done = 2'b01;
      tick(); ctl("E_ack", 6'b00_01_1_0);
      core_done = 2'b00;
      tick(); ctl("E_done", 6'b00_00_0_1);
      start = 1'b0;
      tick(); ctl("E_idle2", 6'b00_00_0_0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
